data_sram_confreg: RTL and testbench

Responder for the CPU's data SRAM port: a synchronous, byte-writable word RAM plus a small memory-mapped configuration register window (LEDs, switches, free-running timer, scratch, write counter). It sits outside the CPU core, on the far side of the `data_sram_*` interface, and answers every enabled access with one-cycle read latency, as the MEM stage expects. A second instance with `wen` tied to 0 serves as the instruction memory.

---
 rtl/data_sram_confreg_if.sv | 24 ++
 rtl/data_sram_confreg.sv | 123 ++++++++++++
 tb/tb_data_sram_confreg.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_confreg_if.sv
// rtl/data_sram_confreg_if.sv - data SRAM port bundle between CPU and memory responder
interface data_sram_confreg_if;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport master (
        output sram_en,
        output sram_wen,
        output sram_addr,
        output sram_wdata,
        input  sram_rdata
    );

    modport slave (
        input  sram_en,
        input  sram_wen,
        input  sram_addr,
        input  sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/data_sram_confreg.sv
// rtl/data_sram_confreg.sv - byte-writable word RAM plus config register window, 1-cycle read
module data_sram_confreg #(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] CONF_BASE = 32'hBFAF_0000,
    parameter logic [31:0] CONF_MASK = 32'hFFFF_0000
) (
    input  logic               clk,
    input  logic               resetn,
    data_sram_confreg_if.slave sram,
    input  logic [7:0]         switch,
    output logic [15:0]        led
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [13:0] OFF_LED     = 14'd0;
    localparam logic [13:0] OFF_SWITCH  = 14'd1;
    localparam logic [13:0] OFF_TIMER   = 14'd2;
    localparam logic [13:0] OFF_SCRATCH = 14'd3;
    localparam logic [13:0] OFF_WCOUNT  = 14'd4;

    logic [31:0] mem [DEPTH];

    logic [15:0] led_q;
    logic [31:0] timer_q;
    logic [31:0] timer_d;
    logic [31:0] scratch_q;
    logic [31:0] wcount_q;
    logic [31:0] rdata_q;
    logic [7:0]  sw_meta_q;
    logic [7:0]  sw_sync_q;
    logic [31:0] conf_rdata;

    logic              access;
    logic              is_write;
    logic              conf_hit;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [13:0]       conf_off;

    // Reset gates every access so nothing presented during reset has an effect.
    assign access   = sram.sram_en & resetn;
    assign is_write = access & (|sram.sram_wen);
    assign conf_hit = (sram.sram_addr & CONF_MASK) == CONF_BASE;
    assign ram_we   = is_write & ~conf_hit;
    assign ram_idx  = sram.sram_addr[ADDR_W+1:2];
    assign conf_off = sram.sram_addr[15:2];

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Config read mux; values are pre-write so reads are read-first.
    always_comb begin
        conf_rdata = 32'd0;
        case (conf_off)
            OFF_LED:     conf_rdata = {16'd0, led_q};
            OFF_SWITCH:  conf_rdata = {24'd0, sw_sync_q};
            OFF_TIMER:   conf_rdata = timer_q;
            OFF_SCRATCH: conf_rdata = scratch_q;
            OFF_WCOUNT:  conf_rdata = wcount_q;
            default:     conf_rdata = 32'd0;
        endcase
    end

    // Timer always advances; a write only overrides strobed bytes of the incremented value.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (is_write && conf_hit && (conf_off == OFF_TIMER)) begin
            timer_d = byte_merge(timer_q + 32'd1, sram.sram_wdata, sram.sram_wen);
        end
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && sram.sram_wen[i]) begin
                mem[ram_idx][8*i +: 8] <= sram.sram_wdata[8*i +: 8];
            end
        end
    end

    // Config registers, switch synchronizer and registered read data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_q     <= 16'd0;
            timer_q   <= 32'd0;
            scratch_q <= 32'd0;
            wcount_q  <= 32'd0;
            rdata_q   <= 32'd0;
            sw_meta_q <= 8'd0;
            sw_sync_q <= 8'd0;
        end else begin
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            timer_q   <= timer_d;
            if (ram_we) begin
                wcount_q <= wcount_q + 32'd1;
            end
            if (is_write && conf_hit && (conf_off == OFF_LED)) begin
                if (sram.sram_wen[0]) led_q[7:0]  <= sram.sram_wdata[7:0];
                if (sram.sram_wen[1]) led_q[15:8] <= sram.sram_wdata[15:8];
            end
            if (is_write && conf_hit && (conf_off == OFF_SCRATCH)) begin
                scratch_q <= byte_merge(scratch_q, sram.sram_wdata, sram.sram_wen);
            end
            if (access) begin
                rdata_q <= conf_hit ? conf_rdata : mem[ram_idx];
            end
        end
    end

    assign sram.sram_rdata = rdata_q;
    assign led             = led_q;

endmodule

// File: tb/tb_data_sram_confreg.sv
// tb/tb_data_sram_confreg.sv - randomized self-checking bench against a behavioural memory/register model
module tb_data_sram_confreg;

    localparam logic [31:0] CB = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  switch_r = 8'd0;
    logic [15:0] led;

    data_sram_confreg_if bus();

    data_sram_confreg dut (
        .clk    (clk),
        .resetn (resetn),
        .sram   (bus),
        .switch (switch_r),
        .led    (led)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [int];
    logic [15:0] led_m;
    logic [31:0] t_base, scratch_m, wcount_m, exp_rd;
    int          t_cyc, cyc, sw_cyc;
    logic [7:0]  sw_now, sw_prev;
    bit          exp_ok;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] apply_strobes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                  input logic [3:0] w);
        logic [31:0] m;
        m = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    function automatic logic [31:0] timer_now();
        return t_base + 32'(cyc - t_cyc);
    endfunction

    function automatic logic [7:0] sw_visible();
        return (cyc - sw_cyc >= 2) ? sw_now : sw_prev;
    endfunction

    function automatic logic [31:0] conf_value(input int off);
        case (off)
            0:       return {16'd0, led_m};
            1:       return {24'd0, sw_visible()};
            2:       return timer_now();
            3:       return scratch_m;
            4:       return wcount_m;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_switch(input logic [7:0] v);
        sw_prev  = sw_visible();
        sw_now   = v;
        sw_cyc   = cyc;
        switch_r = v;
    endtask

    task automatic step(input logic rn, input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
        int off;
        int idx;
        logic [31:0] nv;
        @(negedge clk);
        resetn         = rn;
        bus.sram_en    = en;
        bus.sram_wen   = wen;
        bus.sram_addr  = addr;
        bus.sram_wdata = wdata;
        if (!rn) begin
            exp_rd = 32'd0; exp_ok = 1'b1;
            led_m = 16'd0; scratch_m = 32'd0; wcount_m = 32'd0;
            t_base = 32'd0; t_cyc = cyc + 1;
            sw_prev = 8'd0; sw_now = switch_r; sw_cyc = cyc + 1;
        end else if (en) begin
            if (addr[31:16] == CB[31:16]) begin
                off = int'(addr[15:2]);
                exp_rd = conf_value(off);
                exp_ok = 1'b1;
                if (wen != 4'd0) begin
                    case (off)
                        0: led_m = apply_strobes({16'd0, led_m}, wdata, wen & 4'b0011) & 32'h0000_FFFF;
                        2: begin
                            nv = apply_strobes(timer_now() + 32'd1, wdata, wen);
                            t_base = nv; t_cyc = cyc + 1;
                        end
                        3: scratch_m = apply_strobes(scratch_m, wdata, wen);
                        default: ;
                    endcase
                end
            end else begin
                idx = int'(addr[15:2]);
                exp_ok = mem_m.exists(idx);
                if (exp_ok) exp_rd = mem_m[idx];
                if (wen != 4'd0) begin
                    mem_m[idx] = apply_strobes(mem_m.exists(idx) ? mem_m[idx] : 32'd0, wdata, wen);
                    wcount_m = wcount_m + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (exp_ok) check32("rdata", bus.sram_rdata, exp_rd);
        check32("led", {16'd0, led}, {16'd0, led_m});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    int pool [8] = '{0, 1, 4, 8, 16, 100, 1000, 16383};

    initial begin
        bus.sram_en = 1'b0; bus.sram_wen = 4'd0; bus.sram_addr = 32'd0; bus.sram_wdata = 32'd0;
        cyc = 0; exp_ok = 1'b0; exp_rd = 32'd0;
        led_m = 16'd0; t_base = 32'd0; t_cyc = 0; scratch_m = 32'd0; wcount_m = 32'd0;
        sw_now = 8'd0; sw_prev = 8'd0; sw_cyc = 0;

        step(1'b0, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        check32("reset_rdata", bus.sram_rdata, 32'd0);
        check32("reset_led", {16'd0, led}, 32'd0);

        idle(10);
        step(1'b1, 1'b1, 4'd0, CB + 32'h8, 32'd0);
        check32("timer_at_10", bus.sram_rdata, 32'd10);

        step(1'b1, 1'b1, 4'hF, 32'h10, 32'h1122_3344);
        step(1'b1, 1'b1, 4'b0010, 32'h10, 32'hAABB_CCDD);
        step(1'b1, 1'b1, 4'd0, 32'h10, 32'd0);
        check32("ram_strobe", bus.sram_rdata, 32'h1122_CC44);

        step(1'b1, 1'b1, 4'hF, 32'h20, 32'd0);
        step(1'b1, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        check32("read_first_old", bus.sram_rdata, 32'd0);
        step(1'b1, 1'b1, 4'd0, 32'h20, 32'd0);
        check32("b2b_new", bus.sram_rdata, 32'hDEAD_BEEF);
        idle(3);
        check32("hold", bus.sram_rdata, 32'hDEAD_BEEF);

        step(1'b1, 1'b1, 4'hF, 32'h0001_0000, 32'h5A5A_5A5A);
        step(1'b1, 1'b1, 4'd0, 32'h0000_0000, 32'd0);
        check32("alias", bus.sram_rdata, 32'h5A5A_5A5A);
        step(1'b1, 1'b1, 4'd0, CB + 32'h10, 32'd0);
        check32("wcount", bus.sram_rdata, 32'd5);

        step(1'b1, 1'b1, 4'hF, CB, 32'h0001_ABCD);
        check32("led_out", {16'd0, led}, 32'h0000_ABCD);
        step(1'b1, 1'b1, 4'd0, CB, 32'd0);
        check32("led_read", bus.sram_rdata, 32'h0000_ABCD);

        set_switch(8'hA5);
        step(1'b1, 1'b1, 4'd0, CB + 32'h4, 32'd0);
        step(1'b1, 1'b1, 4'd0, CB + 32'h4, 32'd0);
        step(1'b1, 1'b1, 4'd0, CB + 32'h4, 32'd0);
        check32("switch_2cyc", bus.sram_rdata, 32'h0000_00A5);
        step(1'b1, 1'b1, 4'hF, CB + 32'h4, 32'h0000_0000);
        step(1'b1, 1'b1, 4'd0, CB + 32'h4, 32'd0);
        check32("switch_ro", bus.sram_rdata, 32'h0000_00A5);

        step(1'b1, 1'b1, 4'hF, CB + 32'h8, 32'h0000_00FF);
        step(1'b1, 1'b1, 4'b1000, CB + 32'h8, 32'h0000_0000);
        step(1'b1, 1'b1, 4'd0, CB + 32'h8, 32'd0);
        check32("timer_merge", bus.sram_rdata, 32'h0000_0100);
        step(1'b1, 1'b1, 4'd0, CB + 32'h8, 32'd0);
        check32("timer_counts", bus.sram_rdata, 32'h0000_0101);
        step(1'b1, 1'b1, 4'hF, CB + 32'h8, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 4'd0, CB + 32'h8, 32'd0);
        step(1'b1, 1'b1, 4'd0, CB + 32'h8, 32'd0);
        check32("timer_wrap", bus.sram_rdata, 32'd0);

        step(1'b1, 1'b1, 4'hF, 32'h40, 32'h1234_5678);
        step(1'b1, 1'b1, 4'd0, 32'h40, 32'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        check32("midrd_rdata", bus.sram_rdata, 32'd0);
        check32("midrd_led", {16'd0, led}, 32'd0);
        step(1'b1, 1'b1, 4'd0, CB + 32'h8, 32'd0);
        check32("midrd_timer", bus.sram_rdata, 32'd0);
        step(1'b1, 1'b1, 4'd0, 32'h40, 32'd0);
        check32("ram_kept", bus.sram_rdata, 32'h1234_5678);

        foreach (pool[i]) step(1'b1, 1'b1, 4'hF, 32'(pool[i]) << 2, $urandom);

        for (int n = 0; n < 600; n++) begin
            int r;
            logic [31:0] a;
            logic [3:0]  w;
            logic [15:0] hi;
            r = $urandom_range(0, 99);
            w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            if ((cyc - sw_cyc >= 3) && ($urandom_range(0, 19) == 0)) set_switch(8'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 6))
                    0: a = CB;
                    1: a = CB + 32'h4;
                    2: a = CB + 32'h8;
                    3: a = CB + 32'hC;
                    4: a = CB + 32'h10;
                    5: a = CB + 32'h14;
                    default: a = CB + 32'hFFFC;
                endcase
            end else begin
                hi = 16'($urandom);
                if (hi == CB[31:16]) hi = 16'd0;
                a = {hi, 16'd0} | (32'(pool[$urandom_range(0, 7)]) << 2) | 32'($urandom_range(0, 3));
            end
            step((r < 2) ? 1'b0 : 1'b1, (r >= 15) ? 1'b1 : 1'b0, w, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
